// File: rtl/cclut_lookup_sched.sv
// Round-robin scheduler sharing the two CCLUT ROM read ports among
// per-CFEB pattern-finder requesters; results come back tagged.
module cclut_lookup_sched #(
    parameter int MXREQ   = 7,
    parameter int MXADRB  = 11,
    parameter int MXPIDB  = 3,
    parameter int MXDATB  = 9,
    parameter int MXIDB   = 3,
    parameter int LUT_LAT = 1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [MXREQ-1:0]        req_vld,
    input  logic [MXREQ*MXADRB-1:0] req_carry,
    input  logic [MXREQ*MXPIDB-1:0] req_pid,
    output logic [MXREQ-1:0]        req_ack,
    output logic [MXADRB-1:0]       lut_adr0,
    output logic [MXADRB-1:0]       lut_adr1,
    output logic [MXPIDB-1:0]       lut_pid0,
    output logic [MXPIDB-1:0]       lut_pid1,
    input  logic [MXDATB-1:0]       lut_rd0,
    input  logic [MXDATB-1:0]       lut_rd1,
    output logic                    res_vld0,
    output logic                    res_vld1,
    output logic [MXIDB-1:0]        res_id0,
    output logic [MXIDB-1:0]        res_id1,
    output logic [MXDATB-1:0]       res_data0,
    output logic [MXDATB-1:0]       res_data1,
    output logic                    busy,
    output logic [15:0]             stall_cnt
);

    localparam logic [MXIDB:0]    NREQ    = (MXIDB+1)'(MXREQ);
    localparam logic [MXPIDB-1:0] PID_MAX = MXPIDB'(4);

    logic [MXIDB-1:0]  ptr;
    logic [MXIDB-1:0]  ptr_nxt;
    logic              g0_hit;
    logic              g1_hit;
    logic [MXIDB-1:0]  g0_idx;
    logic [MXIDB-1:0]  g1_idx;
    logic [MXIDB:0]    scan;
    logic [MXADRB-1:0] sel_adr0;
    logic [MXADRB-1:0] sel_adr1;
    logic [MXPIDB-1:0] sel_pid0;
    logic [MXPIDB-1:0] sel_pid1;

    logic [1:0]                         g_hit;
    logic [1:0]                         g_blk;
    logic [1:0][MXIDB-1:0]              g_idx;
    logic [1:0][LUT_LAT:0]              pv;
    logic [1:0][LUT_LAT:0]              pb;
    logic [1:0][LUT_LAT:0][MXIDB-1:0]   pt;

    function automatic logic [MXIDB-1:0] wrap_inc(input logic [MXIDB-1:0] x);
        return ({1'b0, x} == NREQ - 1'b1) ? '0 : x + 1'b1;
    endfunction

    // Wrapped scan from ptr; the second hit never passes ptr again.
    always_comb begin
        g0_hit = 1'b0;
        g1_hit = 1'b0;
        g0_idx = '0;
        g1_idx = '0;
        scan   = '0;
        if (enable && reset_n) begin
            for (int k = 0; k < MXREQ; k++) begin
                scan = {1'b0, ptr} + (MXIDB+1)'(k);
                if (scan >= NREQ)
                    scan = scan - NREQ;
                if (req_vld[scan[MXIDB-1:0]]) begin
                    if (!g0_hit) begin
                        g0_hit = 1'b1;
                        g0_idx = scan[MXIDB-1:0];
                    end else if (!g1_hit) begin
                        g1_hit = 1'b1;
                        g1_idx = scan[MXIDB-1:0];
                    end
                end
            end
        end
    end

    always_comb begin
        req_ack  = '0;
        sel_adr0 = '0;
        sel_adr1 = '0;
        sel_pid0 = '0;
        sel_pid1 = '0;
        for (int i = 0; i < MXREQ; i++) begin
            if (g0_idx == MXIDB'(i)) begin
                sel_adr0 = req_carry[i*MXADRB +: MXADRB];
                sel_pid0 = req_pid[i*MXPIDB +: MXPIDB];
                if (g0_hit)
                    req_ack[i] = 1'b1;
            end
            if (g1_idx == MXIDB'(i)) begin
                sel_adr1 = req_carry[i*MXADRB +: MXADRB];
                sel_pid1 = req_pid[i*MXPIDB +: MXPIDB];
                if (g1_hit)
                    req_ack[i] = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_nxt = ptr;
        if (g1_hit)
            ptr_nxt = wrap_inc(g1_idx);
        else if (g0_hit)
            ptr_nxt = wrap_inc(g0_idx);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            ptr <= '0;
        else
            ptr <= ptr_nxt;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lut_adr0 <= '0;
            lut_adr1 <= '0;
            lut_pid0 <= '0;
            lut_pid1 <= '0;
        end else begin
            if (g0_hit) begin
                lut_adr0 <= sel_adr0;
                lut_pid0 <= sel_pid0;
            end
            if (g1_hit) begin
                lut_adr1 <= sel_adr1;
                lut_pid1 <= sel_pid1;
            end
        end
    end

    assign g_hit = {g1_hit, g0_hit};
    assign g_idx = {g1_idx, g0_idx};
    assign g_blk = {sel_pid1 > PID_MAX, sel_pid0 > PID_MAX};

    // Stage 0 sits alongside lut_adr; stage LUT_LAT lines up with lut_rd.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pv <= '0;
            pb <= '0;
            pt <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                pv[p][0] <= g_hit[p];
                pb[p][0] <= g_blk[p];
                pt[p][0] <= g_idx[p];
                for (int s = 1; s <= LUT_LAT; s++) begin
                    pv[p][s] <= pv[p][s-1];
                    pb[p][s] <= pb[p][s-1];
                    pt[p][s] <= pt[p][s-1];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            res_vld0  <= 1'b0;
            res_vld1  <= 1'b0;
            res_id0   <= '0;
            res_id1   <= '0;
            res_data0 <= '0;
            res_data1 <= '0;
        end else begin
            res_vld0 <= pv[0][LUT_LAT];
            res_vld1 <= pv[1][LUT_LAT];
            if (pv[0][LUT_LAT]) begin
                res_id0   <= pt[0][LUT_LAT];
                res_data0 <= pb[0][LUT_LAT] ? '0 : lut_rd0;
            end
            if (pv[1][LUT_LAT]) begin
                res_id1   <= pt[1][LUT_LAT];
                res_data1 <= pb[1][LUT_LAT] ? '0 : lut_rd1;
            end
        end
    end

    assign busy = |pv;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            stall_cnt <= '0;
        else if (|(req_vld & ~req_ack) && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end

endmodule
